// File: rtl/n64_vinfo_tracker.sv
// N64 video-info tracker: data-phase counter, per-field line count, hysteresis-filtered PAL/NTSC and 240p/480i decisions.
// Optional pixel-per-line statistics are compiled in with `define VINFO_HSTAT_EN.
module n64_vinfo_tracker #(
  parameter int LINE_W        = 10,
  parameter int PAL_THRESH    = 288,
  parameter int HYST_W        = 3,
  parameter int STABLE_FIELDS = 2,
  parameter int PX_W          = 11
) (
  input  logic              VCLK,
  input  logic              nRST,
  input  logic              nDSYNC,
  input  logic [3:0]        Sync_pre,
  input  logic [3:0]        Sync_cur,
  output logic [1:0]        data_cnt,
  output logic              vmode,
  output logic              n64_480i,
  output logic              field_id,
  output logic [LINE_W-1:0] field_lines,
  output logic              vinfo_valid,
  output logic [PX_W-1:0]   px_per_line
);

  localparam logic [LINE_W-1:0] LINE_MAX = '1;
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
  localparam logic [LINE_W:0]   PAL_T    = (LINE_W+1)'(PAL_THRESH);
  localparam logic [HYST_W-1:0] H_MAX    = '1;
  localparam logic [HYST_W-1:0] H_ONE    = HYST_W'(1);
  localparam logic [HYST_W-1:0] STABLE   = HYST_W'(STABLE_FIELDS);

  function automatic logic [LINE_W-1:0] line_inc(input logic [LINE_W-1:0] v);
    return (v == LINE_MAX) ? v : v + LINE_ONE;
  endfunction

  function automatic logic [HYST_W-1:0] fld_inc(input logic [HYST_W-1:0] v);
    return (v == H_MAX) ? v : v + H_ONE;
  endfunction

  logic qual, vs_pos, vs_neg, hs_pos, hs_neg;
  logic unused_sync;

  assign qual   = !nDSYNC;
  assign vs_pos = qual & !Sync_pre[3] &  Sync_cur[3];
  assign vs_neg = qual &  Sync_pre[3] & !Sync_cur[3];
  assign hs_pos = qual & !Sync_pre[1] &  Sync_cur[1];
  assign hs_neg = qual &  Sync_pre[1] & !Sync_cur[1];
  assign unused_sync = ^{Sync_pre[2], Sync_pre[0], Sync_cur[2], Sync_cur[0]};

  logic [LINE_W-1:0] line_cnt;
  logic [HYST_W-1:0] vm_hcnt, il_hcnt, fld_cnt;
  logic [HYST_W-1:0] vm_hcnt_nxt, il_hcnt_nxt;
  logic              pal_cand, fid_new, il_cand;
  logic              vm_flip, il_flip, line_sat;

  assign pal_cand = ({1'b0, line_cnt} >= PAL_T);
  assign fid_new  = hs_neg;
  assign il_cand  = (fid_new != field_id);
  assign line_sat = (line_cnt == LINE_MAX);

  // Two independent hysteresis filters: vmode judged at field end, n64_480i at field start.
  always_comb begin
    vm_hcnt_nxt = vm_hcnt;
    vm_flip     = 1'b0;
    il_hcnt_nxt = il_hcnt;
    il_flip     = 1'b0;
    if (vs_pos) begin
      if (pal_cand == vmode) begin
        vm_hcnt_nxt = '0;
      end else if (vm_hcnt + H_ONE == STABLE) begin
        vm_hcnt_nxt = '0;
        vm_flip     = 1'b1;
      end else begin
        vm_hcnt_nxt = vm_hcnt + H_ONE;
      end
    end
    if (vs_neg) begin
      if (il_cand == n64_480i) begin
        il_hcnt_nxt = '0;
      end else if (il_hcnt + H_ONE == STABLE) begin
        il_hcnt_nxt = '0;
        il_flip     = 1'b1;
      end else begin
        il_hcnt_nxt = il_hcnt + H_ONE;
      end
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      data_cnt    <= 2'd0;
      line_cnt    <= '0;
      field_lines <= '0;
      field_id    <= 1'b0;
      vmode       <= 1'b0;
      n64_480i    <= 1'b1;
      vm_hcnt     <= '0;
      il_hcnt     <= '0;
      fld_cnt     <= '0;
      vinfo_valid <= 1'b0;
    end else begin
      data_cnt <= nDSYNC ? data_cnt + 2'd1 : 2'd1;
      // vsync wins over a coincident hsync so the new field starts at zero
      if (vs_pos) begin
        field_lines <= line_cnt;
        line_cnt    <= '0;
      end else if (hs_pos) begin
        line_cnt <= line_inc(line_cnt);
      end
      if (vs_neg) field_id <= fid_new;
      vm_hcnt <= vm_hcnt_nxt;
      il_hcnt <= il_hcnt_nxt;
      if (vm_flip) vmode    <= ~vmode;
      if (il_flip) n64_480i <= ~n64_480i;
      // valid is sticky once settled; only a decision flip or lost vsync drops it
      if (vm_flip || il_flip || line_sat) begin
        fld_cnt     <= '0;
        vinfo_valid <= 1'b0;
      end else begin
        if (vs_pos) fld_cnt <= fld_inc(fld_cnt);
        if (fld_cnt >= STABLE && vm_hcnt == '0 && il_hcnt == '0) vinfo_valid <= 1'b1;
      end
    end
  end

`ifdef VINFO_HSTAT_EN
  localparam logic [PX_W-1:0] PX_MAX = '1;
  localparam logic [PX_W-1:0] PX_ONE = PX_W'(1);

  function automatic logic [PX_W-1:0] px_inc(input logic [PX_W-1:0] v);
    return (v == PX_MAX) ? v : v + PX_ONE;
  endfunction

  logic [PX_W-1:0] px_cnt;

  // The hsync cycle itself opens the next line, hence the reload to 1.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      px_cnt      <= '0;
      px_per_line <= '0;
    end else if (hs_pos) begin
      px_per_line <= px_inc(px_cnt);
      px_cnt      <= PX_ONE;
    end else if (qual) begin
      px_cnt <= px_inc(px_cnt);
    end
  end
`else
  assign px_per_line = '0;
`endif

endmodule
